// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and instruction-window sizing.
package fetch_unit_pkg;

  localparam int INSTR_MAX_BYTES = 15;
  localparam int INSTR_BITS      = 8 * INSTR_MAX_BYTES;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_EXEC    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory read port, decode presentation and execute commit.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int WINDOW_BYTES = 16
) ();

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [31:0]               mem_req_addr;
  logic                      mem_rsp_valid;
  logic [8*WINDOW_BYTES-1:0] mem_rsp_data;
  logic                      instr_valid;
  logic                      instr_ready;
  logic [INSTR_BITS-1:0]     instr_bytes;
  logic [31:0]               instr_eip;
  logic                      commit_valid;
  logic [31:0]               next_eip;
  logic                      commit_ready;
  logic [31:0]               retired_count;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr_bytes, instr_eip,
           commit_ready, retired_count,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           commit_valid, next_eip
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr_bytes, instr_eip,
           commit_ready, retired_count,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           commit_valid, next_eip
  );

endinterface

// File: rtl/fetch_buf.sv
// Instruction window buffer: captures the low INSTR_MAX_BYTES of a memory window on load.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int WINDOW_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [8*WINDOW_BYTES-1:0] data,
  output logic [INSTR_BITS-1:0]     bytes
);

  logic [INSTR_BITS-1:0] win_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (load) begin
      win_q <= data[INSTR_BITS-1:0];
    end
  end

  assign bytes = win_q;

  // Bytes beyond the longest instruction are never presented to decode.
  generate
    if (WINDOW_BYTES > INSTR_MAX_BYTES) begin : g_spare
      logic unused_spare_bytes;
      assign unused_spare_bytes = ^data[8*WINDOW_BYTES-1:INSTR_BITS];
    end
  endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM (REQ -> WAIT -> PRESENT -> EXEC).
// Optional retired-instruction counter enabled by macro FETCH_RETIRE_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
  parameter int          WINDOW_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);

  fetch_state_t state;
  logic [31:0]  eip_q;
  logic         req_valid_q;
  logic         instr_valid_q;
  logic         commit_ready_q;
  logic         load;

  assign load = (state == ST_WAIT) && bus.mem_rsp_valid;

  // Handshake outputs are registered alongside the state so each is high only in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_REQ;
      eip_q          <= RESET_EIP;
      req_valid_q    <= 1'b1;
      instr_valid_q  <= 1'b0;
      commit_ready_q <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_valid_q && bus.mem_req_ready) begin
            state       <= ST_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.mem_rsp_valid) begin
            state         <= ST_PRESENT;
            instr_valid_q <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (bus.instr_ready) begin
            state          <= ST_EXEC;
            instr_valid_q  <= 1'b0;
            commit_ready_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (bus.commit_valid) begin
            state          <= ST_REQ;
            eip_q          <= bus.next_eip;
            commit_ready_q <= 1'b0;
            req_valid_q    <= 1'b1;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  fetch_buf #(
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (bus.mem_rsp_data),
    .bytes (bus.instr_bytes)
  );

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = eip_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.instr_eip     = eip_q;
  assign bus.commit_ready  = commit_ready_q;

`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (commit_ready_q && bus.commit_valid) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.retired_count = retired_q;
`else
  assign bus.retired_count = '0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_EIP, default 32'h0000_0000, EIP loaded on reset.
REQ-002 SHALL have parameter WINDOW_BYTES, default 16, bytes returned per memory read (at least 15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req_valid  output  1  read request valid.
REQ-006 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port mem_req_addr  output  32  byte address of window (current EIP).
REQ-008 SHALL have port mem_rsp_valid  input  1  read data valid (one-cycle pulse).
REQ-009 SHALL have port mem_rsp_data  input  8*WINDOW_BYTES  window; byte 0 in bits 7:0 is the byte at mem_req_addr.
REQ-010 SHALL have port instr_valid  output  1  instruction window valid to decode.
REQ-011 SHALL have port instr_ready  input  1  decode accepts window.
REQ-012 SHALL have port instr_bytes  output  120  lowest 15 bytes of latched window.
REQ-013 SHALL have port instr_eip  output  32  EIP of presented instruction (cfu eip input).
REQ-014 SHALL have port commit_valid  input  1  execute retired instruction; next_eip valid.
REQ-015 SHALL have port next_eip  input  32  cfu next_eip.
REQ-016 SHALL have port commit_ready  output  1  fetch unit accepts commit.
REQ-017 SHALL have port retired_count  output  32  retired-instruction counter (see Configuration).

Function
REQ-018 SHALL implement FSM states REQ, WAIT, PRESENT, EXEC.
REQ-019 REQ: mem_req_valid=1, mem_req_addr=eip; on mem_req_valid&mem_req_ready -> WAIT next cycle.
REQ-020 WAIT: on mem_rsp_valid, latch window into buffer -> PRESENT; mem_rsp_valid in any other state SHALL be ignored.
REQ-021 PRESENT: instr_valid=1, instr_bytes/instr_eip stable while instr_valid&!instr_ready; on handshake -> EXEC.
REQ-022 EXEC: commit_ready=1; on commit_valid, eip<=next_eip -> REQ; commit_valid in other states SHALL be ignored.
REQ-023 instr_valid, commit_ready, mem_req_valid SHALL each be asserted only in their own state (registered decode of state).
REQ-024 Zero-wait-state memory (ready and rsp both immediate): commit to next mem_req_valid SHALL be 1 cycle; request handshake to instr_valid SHALL be 2 cycles (rsp one cycle after request).
REQ-025 mem_req_addr SHALL be eip unmodified (no alignment); address wrap 32'hFFFF_FFFF->0 is the memory's concern.
REQ-026 next_eip SHALL be taken verbatim, including 32'h0 and wrapped values.
REQ-027 At most one memory request SHALL be outstanding.

Reset
REQ-028 On rst: state=REQ, eip=RESET_EIP, buffer=0, retired_count=0.
REQ-029 Outputs during/after reset: mem_req_valid=1 (first cycle after rst deasserts), instr_valid=0, commit_ready=0, instr_bytes=0, instr_eip=RESET_EIP.
REQ-030 Reset mid-operation SHALL abandon any in-flight request; memory SHALL share rst so no stale response arrives.

Configuration
REQ-031 Macro FETCH_RETIRE_COUNT_EN: when defined, retired_count SHALL increment (mod 2^32) on each commit handshake.
REQ-032 When undefined, retired_count SHALL be constant 0 and no counter register synthesised.

Structure
REQ-033 FSM state encodings and INSTR_MAX_BYTES (15) SHALL live in shared defines.v.
REQ-034 Window register and byte extraction SHALL be sub-module fetch_buf (load, data in, 120-bit out).

Verification
REQ-035 Reset with RESET_EIP=32'h1000, ready=1 -> mem_req_addr=32'h1000, mem_req_valid=1 cycle after rst drops.
REQ-036 rsp data bytes 0..15 = 8'h00..8'h0F -> instr_bytes[7:0]=8'h00, [119:112]=8'h0E, instr_eip=32'h1000.
REQ-037 instr_ready held 0 for 5 cycles -> instr_valid and instr_bytes stable all 5 cycles, commit_ready=0.
REQ-038 commit next_eip=32'h2000 -> next mem_req_addr=32'h2000; retired_count=1 with macro, 0 without.
REQ-039 mem_req_ready=0 for 3 cycles then 1; spurious mem_rsp_valid in REQ -> single request, spurious data not latched.
REQ-040 rst asserted in WAIT -> state REQ, eip=RESET_EIP, instr_valid=0, retired_count=0.
